// File: rtl/tx_req_engine_if.sv
// Stream bundle for tx_req_engine: enqueue, doorbell, scheduler request,
// packet and request-status channels. The engine connects through the slave modport.
interface tx_req_engine_if #(
  parameter int QUEUE_INDEX_WIDTH = 6,
  parameter int REQ_TAG_WIDTH     = 8,
  parameter int LEN_WIDTH         = 16
);
  logic [QUEUE_INDEX_WIDTH-1:0] s_axis_enq_queue;
  logic [LEN_WIDTH-1:0]         s_axis_enq_len;
  logic                         s_axis_enq_valid;
  logic                         s_axis_enq_ready;

  logic [QUEUE_INDEX_WIDTH-1:0] m_axis_doorbell_queue;
  logic                         m_axis_doorbell_valid;

  logic [QUEUE_INDEX_WIDTH-1:0] s_axis_tx_req_queue;
  logic [REQ_TAG_WIDTH-1:0]     s_axis_tx_req_tag;
  logic                         s_axis_tx_req_valid;
  logic                         s_axis_tx_req_ready;

  logic [QUEUE_INDEX_WIDTH-1:0] m_axis_pkt_queue;
  logic [LEN_WIDTH-1:0]         m_axis_pkt_len;
  logic                         m_axis_pkt_valid;
  logic                         m_axis_pkt_ready;

  logic [LEN_WIDTH-1:0]         m_axis_tx_req_status_len;
  logic [REQ_TAG_WIDTH-1:0]     m_axis_tx_req_status_tag;
  logic                         m_axis_tx_req_status_valid;

  modport master (
    output s_axis_enq_queue, s_axis_enq_len, s_axis_enq_valid,
    input  s_axis_enq_ready,
    input  m_axis_doorbell_queue, m_axis_doorbell_valid,
    output s_axis_tx_req_queue, s_axis_tx_req_tag, s_axis_tx_req_valid,
    input  s_axis_tx_req_ready,
    input  m_axis_pkt_queue, m_axis_pkt_len, m_axis_pkt_valid,
    output m_axis_pkt_ready,
    input  m_axis_tx_req_status_len, m_axis_tx_req_status_tag, m_axis_tx_req_status_valid
  );

  modport slave (
    input  s_axis_enq_queue, s_axis_enq_len, s_axis_enq_valid,
    output s_axis_enq_ready,
    output m_axis_doorbell_queue, m_axis_doorbell_valid,
    input  s_axis_tx_req_queue, s_axis_tx_req_tag, s_axis_tx_req_valid,
    output s_axis_tx_req_ready,
    output m_axis_pkt_queue, m_axis_pkt_len, m_axis_pkt_valid,
    input  m_axis_pkt_ready,
    output m_axis_tx_req_status_len, m_axis_tx_req_status_tag, m_axis_tx_req_status_valid
  );
endinterface

// File: rtl/tx_req_engine.sv
// Transmit request engine: per-queue pending-packet table with doorbells and a one-in-flight
// request FSM. Define TX_REQ_ENGINE_STATS_EN to add saturating packet / empty-status counters.
module tx_req_engine #(
  parameter int QUEUE_INDEX_WIDTH = 6,
  parameter int REQ_TAG_WIDTH     = 8,
  parameter int LEN_WIDTH         = 16,
  parameter int COUNT_WIDTH       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef TX_REQ_ENGINE_STATS_EN
  output logic [31:0] stat_pkt_count,
  output logic [31:0] stat_empty_count,
`endif
  tx_req_engine_if.slave bus
);
  localparam int NQ = 1 << QUEUE_INDEX_WIDTH;

  typedef enum logic [1:0] {IDLE, LOOKUP, PKT, STATUS} state_t;
  state_t state, state_nxt;

  logic [COUNT_WIDTH-1:0]       count [NQ];
  logic [LEN_WIDTH-1:0]         plen  [NQ];
  logic [NQ-1:0]                inc_vec, dec_vec;
  logic                         live;
  logic [QUEUE_INDEX_WIDTH-1:0] req_queue, db_queue;
  logic [REQ_TAG_WIDTH-1:0]     req_tag;
  logic [LEN_WIDTH-1:0]         req_len;
  logic                         db_valid;
  logic                         enq_ready, enq_fire, req_ready, req_fire, hit;
  logic                         pkt_valid, status_valid;

  // live holds ready/valid low for the first cycle after reset is released
  assign enq_ready = rst_n && live && (count[bus.s_axis_enq_queue] != '1);
  assign enq_fire  = bus.s_axis_enq_valid && enq_ready;
  assign req_fire  = bus.s_axis_tx_req_valid && req_ready;
  assign hit       = (count[req_queue] != '0);

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (enq_fire) inc_vec[bus.s_axis_enq_queue] = 1'b1;
    if (state == LOOKUP && hit) dec_vec[req_queue] = 1'b1;
  end

  // Same-cycle enqueue and dequeue on one queue leave the count unchanged
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int q = 0; q < NQ; q++) begin
        count[q] <= '0;
        plen[q]  <= '0;
      end
    end else begin
      for (int q = 0; q < NQ; q++) begin
        if (inc_vec[q] && !dec_vec[q]) count[q] <= count[q] + 1'b1;
        if (!inc_vec[q] && dec_vec[q]) count[q] <= count[q] - 1'b1;
        if (inc_vec[q]) plen[q] <= bus.s_axis_enq_len;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_fire) state_nxt = LOOKUP;
      LOOKUP:  state_nxt = hit ? PKT : STATUS;
      PKT:     if (bus.m_axis_pkt_ready) state_nxt = STATUS;
      STATUS:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready    = 1'b0;
    pkt_valid    = 1'b0;
    status_valid = 1'b0;
    case (state)
      IDLE:    req_ready    = rst_n && live;
      PKT:     pkt_valid    = rst_n;
      STATUS:  status_valid = rst_n;
      default: ;
    endcase
  end

  // req_len captures plen at LOOKUP, so a racing enqueue only affects later packets
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      live      <= 1'b0;
      db_valid  <= 1'b0;
      db_queue  <= '0;
      req_queue <= '0;
      req_tag   <= '0;
      req_len   <= '0;
    end else begin
      live     <= 1'b1;
      db_valid <= enq_fire;
      if (enq_fire) db_queue <= bus.s_axis_enq_queue;
      if (req_fire) begin
        req_queue <= bus.s_axis_tx_req_queue;
        req_tag   <= bus.s_axis_tx_req_tag;
      end
      if (state == LOOKUP) req_len <= hit ? plen[req_queue] : '0;
    end
  end

  assign bus.s_axis_enq_ready           = enq_ready;
  assign bus.s_axis_tx_req_ready        = req_ready;
  assign bus.m_axis_doorbell_valid      = db_valid && rst_n;
  assign bus.m_axis_doorbell_queue      = rst_n ? db_queue : '0;
  assign bus.m_axis_pkt_valid           = pkt_valid;
  assign bus.m_axis_pkt_queue           = rst_n ? req_queue : '0;
  assign bus.m_axis_pkt_len             = rst_n ? req_len : '0;
  assign bus.m_axis_tx_req_status_valid = status_valid;
  assign bus.m_axis_tx_req_status_len   = rst_n ? req_len : '0;
  assign bus.m_axis_tx_req_status_tag   = rst_n ? req_tag : '0;

`ifdef TX_REQ_ENGINE_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_pkt_count   <= '0;
      stat_empty_count <= '0;
    end else begin
      if (pkt_valid && bus.m_axis_pkt_ready && stat_pkt_count != '1)
        stat_pkt_count <= stat_pkt_count + 1'b1;
      if (status_valid && req_len == '0 && stat_empty_count != '1)
        stat_empty_count <= stat_empty_count + 1'b1;
    end
  end
`endif
endmodule
